// File: rtl/inst_encoder.sv
// MIPS32 instruction encoder: packs R/I/J field bundles into words and streams
// them to the imem write port at consecutive word addresses.
module inst_encoder #(
    parameter int unsigned W         = 32,
    parameter int unsigned AW        = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Start,
    input  logic          Finish,
    input  logic          InValid,
    output logic          InReady,
    input  logic [1:0]    Fmt,
    input  logic [5:0]    OpCode,
    input  logic [4:0]    Rs,
    input  logic [4:0]    Rt,
    input  logic [4:0]    Rd,
    input  logic [4:0]    Shamt,
    input  logic [5:0]    Funct,
    input  logic [15:0]   Imm,
    input  logic [25:0]   Addr,
    output logic          WrEn,
    input  logic          WrReady,
    output logic [AW-1:0] WrAddr,
    output logic [W-1:0]  WrData,
    output logic [AW:0]   Count,
    output logic          Busy,
    output logic          Done,
    output logic          Err
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = AW + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t       state;
    logic         fin_pend;
    logic [W-1:0] pack_word;
    logic         legal;
    logic         fin_any;
    logic         room;
    logic         accept;
    logic         wr_done;

    // Field packing, same bit layout the decode stage splits on
    always_comb begin
        pack_word = '0;
        case (Fmt)
            2'b00:   pack_word = W'({OpCode, Rs, Rt, Rd, Shamt, Funct});
            2'b01:   pack_word = W'({OpCode, Rs, Rt, Imm});
            2'b10:   pack_word = W'({OpCode, Addr});
            default: pack_word = '0;
        endcase
    end

    assign legal   = (Fmt != 2'b11);
    assign fin_any = Finish | fin_pend;
    // Words already written plus the one held in the output register
    assign room    = (SW'(Count) + SW'(WrEn)) < SW'(DEPTH);
    assign Busy    = (state == ST_LOAD);
    assign Done    = (state == ST_DONE);
    assign InReady = Busy & ~fin_any & room & (~WrEn | WrReady);
    assign accept  = InValid & InReady;
    assign wr_done = WrEn & WrReady;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fin_pend <= 1'b0;
            WrEn     <= 1'b0;
            WrAddr   <= AW'(BASE_ADDR);
            WrData   <= '0;
            Count    <= '0;
            Err      <= 1'b0;
        end else if (Start) begin
            // Restart from any state; a held word is discarded
            state    <= ST_LOAD;
            fin_pend <= 1'b0;
            WrEn     <= 1'b0;
            WrAddr   <= AW'(BASE_ADDR);
            WrData   <= '0;
            Count    <= '0;
            Err      <= 1'b0;
        end else begin
            Err <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (wr_done) begin
                        Count  <= Count + CW'(1);
                        WrAddr <= WrAddr + AW'(1);
                    end
                    if (accept && legal) begin
                        WrEn   <= 1'b1;
                        WrData <= pack_word;
                    end else if (wr_done) begin
                        WrEn <= 1'b0;
                    end
                    if (accept && !legal) begin
                        Err <= 1'b1;
                    end
                    if (wr_done && ((Count + CW'(1)) == CW'(DEPTH))) begin
                        state    <= ST_DONE;
                        fin_pend <= 1'b0;
                    end else if (fin_any) begin
                        // Finish waits for the output register to drain
                        if (!WrEn || wr_done) begin
                            state    <= ST_DONE;
                            fin_pend <= 1'b0;
                        end else begin
                            fin_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Testbench for inst_encoder: directed scenarios plus randomized sessions
// checked against a transaction-level model of the expected imem writes.
module tb_inst_encoder;

    localparam int unsigned AW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned BASE  = 0;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] addr;
    } bundle_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          Start = 1'b0;
    logic          Finish = 1'b0;
    logic          InValid = 1'b0;
    logic          InReady;
    logic [1:0]    Fmt = '0;
    logic [5:0]    OpCode = '0;
    logic [4:0]    Rs = '0;
    logic [4:0]    Rt = '0;
    logic [4:0]    Rd = '0;
    logic [4:0]    Shamt = '0;
    logic [5:0]    Funct = '0;
    logic [15:0]   Imm = '0;
    logic [25:0]   Addr = '0;
    logic          WrEn;
    logic          WrReady = 1'b0;
    logic [AW-1:0] WrAddr;
    logic [31:0]   WrData;
    logic [AW:0]   Count;
    logic          Busy;
    logic          Done;
    logic          Err;

    int  n_cmp = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    wr_t mon_e;
    int  n_legal = 0;
    bit  in_session = 0;
    bit  rand_ready = 0;

    inst_encoder #(.W(32), .AW(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .Start(Start), .Finish(Finish),
        .InValid(InValid), .InReady(InReady), .Fmt(Fmt), .OpCode(OpCode),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct), .Imm(Imm),
        .Addr(Addr), .WrEn(WrEn), .WrReady(WrReady), .WrAddr(WrAddr),
        .WrData(WrData), .Count(Count), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rand_ready) WrReady = ($urandom_range(0, 3) != 0);

    // Instruction word from the MIPS field weights
    function automatic logic [31:0] model_pack(bundle_t b);
        case (b.fmt)
            2'b00: return 32'(b.op) * 32'd67108864 + 32'(b.rs) * 32'd2097152 +
                          32'(b.rt) * 32'd65536 + 32'(b.rd) * 32'd2048 +
                          32'(b.sh) * 32'd64 + 32'(b.fn);
            2'b01: return 32'(b.op) * 32'd67108864 + 32'(b.rs) * 32'd2097152 +
                          32'(b.rt) * 32'd65536 + 32'(b.imm);
            2'b10: return 32'(b.op) * 32'd67108864 + 32'(b.addr);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bundle_t mk(logic [1:0] fmt, logic [5:0] op, logic [4:0] rs,
                                   logic [4:0] rt, logic [4:0] rd, logic [4:0] sh,
                                   logic [5:0] fn, logic [15:0] imm, logic [25:0] addr);
        bundle_t b;
        b.fmt = fmt; b.op = op; b.rs = rs; b.rt = rt; b.rd = rd;
        b.sh = sh; b.fn = fn; b.imm = imm; b.addr = addr;
        return b;
    endfunction

    function automatic bundle_t rand_bundle(logic [1:0] fmt);
        return mk(fmt, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
    endfunction

    // Scoreboard: every completed imem write must match the next expected word
    always @(posedge clk) begin
        if (!rst && WrEn === 1'b1 && WrReady === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%0h data=%08h, required no write", WrAddr, WrData);
            end else begin
                mon_e = exp_q.pop_front();
                if (WrAddr !== mon_e.addr || WrData !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL write_content: got addr=%0h data=%08h, required addr=%0h data=%08h",
                             WrAddr, WrData, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic start_session();
        @(negedge clk);
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        exp_q.delete();
        n_legal = 0;
        in_session = 1;
    endtask

    task automatic finish_session();
        @(negedge clk);
        Finish = 1'b1;
        @(posedge clk);
        #1;
        Finish = 1'b0;
        in_session = 0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                seen = 1;
                break;
            end
        end
    endtask

    // Present a bundle until accepted or the cycle budget runs out
    task automatic send(input bundle_t b, output bit acc, output bit exp_acc, output logic err);
        exp_acc = in_session && (n_legal < DEPTH);
        acc = 0;
        @(negedge clk);
        InValid = 1'b1;
        Fmt = b.fmt; OpCode = b.op; Rs = b.rs; Rt = b.rt; Rd = b.rd;
        Shamt = b.sh; Funct = b.fn; Imm = b.imm; Addr = b.addr;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (InReady === 1'b1) begin
                @(posedge clk);
                acc = 1;
                break;
            end
            @(negedge clk);
        end
        if (acc && b.fmt != 2'b11) begin
            exp_q.push_back('{addr: AW'(BASE + n_legal), data: model_pack(b)});
            n_legal++;
        end
        #1;
        err = Err;
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (WrEn !== 1'b0 || WrAddr !== AW'(BASE) || WrData !== 32'd0 || Count !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got WrEn=%b WrAddr=%0h WrData=%08h Count=%0d, required 0/%0h/0/0",
                     WrEn, WrAddr, WrData, Count, BASE);
        end
        n_cmp++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Err !== 1'b0 || InReady !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: got Busy=%b Done=%b Err=%b InReady=%b, required 0000",
                     Busy, Done, Err, InReady);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (InReady !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_not_ready: got InReady=%b Busy=%b, required 0 0", InReady, Busy);
        end
    endtask

    task automatic test_r_format();
        bit acc, ea;
        logic err;
        WrReady = 1'b1;
        start_session();
        n_cmp++;
        if (Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy: got Busy=%b, required 1", Busy);
        end
        send(mk(2'b00, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0), acc, ea, err);
        n_cmp++;
        if (acc !== ea) begin
            n_fail++;
            $display("FAIL r_accept: got %b, required %b", acc, ea);
        end
        n_cmp++;
        if (WrEn !== 1'b1 || WrData !== 32'h00221820 || WrAddr !== 8'd0) begin
            n_fail++;
            $display("FAIL r_word: got WrEn=%b WrData=%08h WrAddr=%0h, required 1 00221820 0",
                     WrEn, WrData, WrAddr);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (Count !== 9'd1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL r_count: got Count=%0d pending=%0d, required 1 0", Count, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit acc, ea;
        logic err;
        WrReady = 1'b1;
        start_session();
        send(mk(2'b01, 6'd8, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0), acc, ea, err);
        n_cmp++;
        if (acc !== ea || WrData !== 32'h2005FFFF || WrAddr !== 8'd0) begin
            n_fail++;
            $display("FAIL i_word: got acc=%b WrData=%08h WrAddr=%0h, required %b 2005ffff 0",
                     acc, WrData, WrAddr, ea);
        end
        send(mk(2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010), acc, ea, err);
        n_cmp++;
        if (acc !== ea || WrData !== 32'h08000010 || WrAddr !== 8'd1) begin
            n_fail++;
            $display("FAIL j_word: got acc=%b WrData=%08h WrAddr=%0h, required %b 08000010 1",
                     acc, WrData, WrAddr, ea);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (Count !== 9'd2 || exp_q.size() != 0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_count: got Count=%0d pending=%0d Done=%b, required 2 0 0",
                     Count, exp_q.size(), Done);
        end
    endtask

    task automatic test_stall();
        bundle_t b1, b2;
        bit acc, ea;
        logic err;
        b1 = rand_bundle(2'b00);
        b2 = rand_bundle(2'b01);
        WrReady = 1'b1;
        start_session();
        WrReady = 1'b0;
        send(b1, acc, ea, err);
        @(negedge clk);
        InValid = 1'b1;
        Fmt = b2.fmt; OpCode = b2.op; Rs = b2.rs; Rt = b2.rt; Imm = b2.imm;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (WrEn !== 1'b1 || WrAddr !== 8'd0 || WrData !== model_pack(b1) || InReady !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got WrEn=%b WrAddr=%0h WrData=%08h InReady=%b, required 1 0 %08h 0",
                         i, WrEn, WrAddr, WrData, InReady, model_pack(b1));
            end
            @(negedge clk);
        end
        InValid = 1'b0;
        WrReady = 1'b1;
        send(b2, acc, ea, err);
        n_cmp++;
        if (acc !== ea) begin
            n_fail++;
            $display("FAIL stall_resume: got accept=%b, required %b", acc, ea);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (Count !== 9'd2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_count: got Count=%0d pending=%0d, required 2 0", Count, exp_q.size());
        end
    endtask

    task automatic test_depth_limit();
        bit acc, ea;
        logic err;
        WrReady = 1'b1;
        start_session();
        for (int i = 0; i < 6; i++) begin
            send(rand_bundle(2'($urandom_range(0, 2))), acc, ea, err);
            n_cmp++;
            if (acc !== ea) begin
                n_fail++;
                $display("FAIL depth_accept[%0d]: got %b, required %b", i, acc, ea);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Count !== 9'(DEPTH) || InReady !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL depth_done: got Done=%b Busy=%b Count=%0d InReady=%b pending=%0d, required 1 0 %0d 0 0",
                     Done, Busy, Count, InReady, exp_q.size(), DEPTH);
        end
    endtask

    task automatic test_illegal_fmt();
        bit acc, ea;
        logic err;
        logic [1:0] fmts [3];
        fmts[0] = 2'b00; fmts[1] = 2'b11; fmts[2] = 2'b10;
        WrReady = 1'b1;
        start_session();
        for (int i = 0; i < 3; i++) begin
            send(rand_bundle(fmts[i]), acc, ea, err);
            n_cmp++;
            if (acc !== ea || err !== (fmts[i] == 2'b11)) begin
                n_fail++;
                $display("FAIL illegal_err[%0d]: got accept=%b Err=%b, required %b %b",
                         i, acc, err, ea, fmts[i] == 2'b11);
            end
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (Count !== 9'd2 || Err !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL illegal_count: got Count=%0d Err=%b pending=%0d, required 2 0 0",
                     Count, Err, exp_q.size());
        end
    endtask

    task automatic test_restart();
        bit acc, ea, seen;
        logic err;
        WrReady = 1'b1;
        start_session();
        send(rand_bundle(2'b00), acc, ea, err);
        send(rand_bundle(2'b01), acc, ea, err);
        WrReady = 1'b0;
        start_session();
        n_cmp++;
        if (WrEn !== 1'b0 || Count !== '0 || WrAddr !== AW'(BASE) || Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clear: got WrEn=%b Count=%0d WrAddr=%0h Busy=%b, required 0 0 %0h 1",
                     WrEn, Count, WrAddr, Busy, BASE);
        end
        WrReady = 1'b1;
        send(rand_bundle(2'b10), acc, ea, err);
        n_cmp++;
        if (acc !== ea) begin
            n_fail++;
            $display("FAIL restart_accept: got %b, required %b", acc, ea);
        end
        finish_session();
        wait_done(seen);
        n_cmp++;
        if (seen !== 1'b1 || Count !== 9'd1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL restart_finish: got Done=%b Count=%0d pending=%0d, required 1 1 0",
                     seen, Count, exp_q.size());
        end
    endtask

    task automatic test_random();
        bit acc, ea, seen;
        logic err;
        logic [1:0] f;
        rand_ready = 1;
        for (int s = 0; s < 3; s++) begin
            start_session();
            for (int i = 0; i < 5; i++) begin
                f = 2'($urandom_range(0, 3));
                send(rand_bundle(f), acc, ea, err);
                n_cmp++;
                if (acc !== ea || err !== (ea && f == 2'b11)) begin
                    n_fail++;
                    $display("FAIL rand_accept[%0d.%0d]: got accept=%b Err=%b, required %b %b",
                             s, i, acc, err, ea, ea && f == 2'b11);
                end
            end
            finish_session();
            wait_done(seen);
            n_cmp++;
            if (seen !== 1'b1 || Count !== 9'(n_legal) || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL rand_session[%0d]: got Done=%b Count=%0d pending=%0d, required 1 %0d 0",
                         s, seen, Count, exp_q.size(), n_legal);
            end
        end
        rand_ready = 0;
        WrReady = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_r_format();
        test_back_to_back();
        test_stall();
        test_depth_limit();
        test_illegal_fmt();
        test_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
